// File: rtl/pl_mem_pkg.sv
// Shared types and default widths for the pipeline memory arbiter.
// Imported by the arbiter top and its starvation counter.
package pl_mem_pkg;

    localparam int PL_ADDR_W = 32;
    localparam int PL_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_DM   = 2'd2
    } grant_t;

endpackage

// File: rtl/pl_arb_starve_cnt.sv
// Saturating count of consecutive DM grants taken while a fetch was waiting.
// at_max_o tells the arbiter to force the next grant to the fetch port.
module pl_arb_starve_cnt
    import pl_mem_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_max_o
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // clear wins over increment; increment saturates at CNT_MAX
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/pl_mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data memory ports.
// DM has priority; a bounded starvation counter guarantees fetch progress.
module pl_mem_arbiter
    import pl_mem_pkg::*;
#(
    parameter int ADDR_W     = PL_ADDR_W,
    parameter int DATA_W     = PL_DATA_W,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req_i,
    input  logic [ADDR_W-1:0]     if_addr_i,
    output logic [DATA_W-1:0]     if_rdata_o,
    output logic                  if_valid_o,
    output logic                  if_stall_o,
    input  logic                  dm_req_i,
    input  logic                  dm_we_i,
    input  logic [ADDR_W-1:0]     dm_addr_i,
    input  logic [DATA_W-1:0]     dm_wdata_i,
    input  logic [DATA_W/8-1:0]   dm_wstrb_i,
    output logic [DATA_W-1:0]     dm_rdata_o,
    output logic                  dm_valid_o,
    output logic                  dm_stall_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    output logic [DATA_W/8-1:0]   mem_wstrb_o,
    input  logic [DATA_W-1:0]     mem_rdata_i,
    input  logic                  mem_ack_i
);

    localparam int STRB_W = DATA_W / 8;

    arb_state_t          state_q, state_d;
    grant_t              gnt_s;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;
    logic                discard_q, discard_d;
    logic                starve_at_max_s;
    logic                starve_inc_s;
    logic                starve_clr_s;

    // grant decision; only IDLE can start a transaction
    always_comb begin
        gnt_s = GNT_NONE;
        if (state_q == IDLE) begin
            if (dm_req_i && !(if_req_i && starve_at_max_s)) begin
                gnt_s = GNT_DM;
            end else if (if_req_i) begin
                gnt_s = GNT_IF;
            end else begin
                gnt_s = GNT_NONE;
            end
        end else begin
            gnt_s = GNT_NONE;
        end
    end

    assign starve_inc_s = (gnt_s == GNT_DM) && if_req_i;
    assign starve_clr_s = (gnt_s == GNT_IF) || ((state_q == IDLE) && !if_req_i);

    pl_arb_starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_cnt (
        .clk      (clk),
        .rst      (rst),
        .inc_i    (starve_inc_s),
        .clr_i    (starve_clr_s),
        .at_max_o (starve_at_max_s)
    );

    // next state and next memory-side register values
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        discard_d   = discard_q;
        case (state_q)
            IDLE: begin
                case (gnt_s)
                    GNT_DM: begin
                        state_d     = BUSY_DM;
                        mem_req_d   = 1'b1;
                        mem_we_d    = dm_we_i;
                        mem_addr_d  = dm_addr_i;
                        mem_wdata_d = dm_wdata_i;
                        mem_wstrb_d = dm_we_i ? dm_wstrb_i : '0;
                    end
                    GNT_IF: begin
                        state_d     = BUSY_IF;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr_i;
                        mem_wdata_d = '0;
                        mem_wstrb_d = '0;
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
            BUSY_IF: begin
                // a fetch dropped mid-flight still completes, but its data is discarded
                if (mem_ack_i) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    discard_d = 1'b0;
                end else if (!if_req_i) begin
                    discard_d = 1'b1;
                end else begin
                    discard_d = discard_q;
                end
            end
            BUSY_DM: begin
                if (mem_ack_i) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end else begin
                    state_d   = BUSY_DM;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                discard_d = 1'b0;
            end
        endcase
    end

    // state and registered memory-side outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            discard_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            discard_q   <= discard_d;
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_wstrb_o = mem_wstrb_q;

    assign if_valid_o  = (state_q == BUSY_IF) && mem_ack_i && !discard_q;
    assign dm_valid_o  = (state_q == BUSY_DM) && mem_ack_i;
    assign if_rdata_o  = mem_rdata_i;
    assign dm_rdata_o  = mem_rdata_i;
    assign if_stall_o  = if_req_i && !if_valid_o;
    assign dm_stall_o  = dm_req_i && !dm_valid_o;

endmodule

// File: tb/tb_pl_mem_arbiter.sv
// Self-checking bench for pl_mem_arbiter: directed scenarios plus a randomized
// two-port run checked against a word-level memory model.
module tb_pl_mem_arbiter;

    localparam int STARVE_MAX = 4;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        if_stall;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_wstrb;
    logic [31:0] dm_rdata;
    logic        dm_valid;
    logic        dm_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int checks   = 0;
    int failures = 0;

    // memory responder controls
    int          ack_lat      = 0;
    bit          stray_ack    = 1'b0;
    bit          rdata_ovr_en = 1'b0;
    logic [31:0] rdata_ovr    = 32'h0;
    int          rsp_wait;
    bit          rsp_busy;

    logic [31:0] phys_mem [logic [31:0]];
    logic [31:0] ref_mem  [logic [31:0]];

    pl_mem_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_rdata_o  (if_rdata),
        .if_valid_o  (if_valid),
        .if_stall_o  (if_stall),
        .dm_req_i    (dm_req),
        .dm_we_i     (dm_we),
        .dm_addr_i   (dm_addr),
        .dm_wdata_i  (dm_wdata),
        .dm_wstrb_i  (dm_wstrb),
        .dm_rdata_o  (dm_rdata),
        .dm_valid_o  (dm_valid),
        .dm_stall_o  (dm_stall),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_wstrb_o (mem_wstrb),
        .mem_rdata_i (mem_rdata),
        .mem_ack_i   (mem_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] merge_word(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] strb);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] phys_read(input logic [31:0] a);
        return phys_mem.exists(a) ? phys_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    // memory: acks ack_lat cycles after it sees mem_req (random 1..4 when ack_lat==0)
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        rsp_busy  = 1'b0;
        rsp_wait  = 0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (rst) begin
                rsp_busy = 1'b0;
            end else if (rsp_busy) begin
                if (rsp_wait == 0) begin
                    mem_ack  = 1'b1;
                    rsp_busy = 1'b0;
                    if (mem_we) begin
                        phys_mem[mem_addr] = merge_word(phys_read(mem_addr), mem_wdata, mem_wstrb);
                        mem_rdata = $urandom();
                    end else begin
                        mem_rdata = rdata_ovr_en ? rdata_ovr : phys_read(mem_addr);
                    end
                end else begin
                    rsp_wait--;
                end
            end else if (mem_req) begin
                rsp_busy = 1'b1;
                rsp_wait = ((ack_lat == 0) ? int'($urandom_range(1, 4)) : ack_lat) - 1;
            end else if (stray_ack) begin
                mem_ack   = 1'b1;
                mem_rdata = $urandom();
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; if_req = 1'b0; dm_req = 1'b1; dm_we = 1'b1;
        if_addr = 32'h0; dm_addr = 32'h44; dm_wdata = 32'hFFFF_FFFF; dm_wstrb = 4'hF;
        repeat (2) @(negedge clk);
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_mem_req act=%0h exp=0", mem_req); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_we act=%0h exp=0", mem_we); end
        checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL rst_mem_addr act=%0h exp=0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL rst_mem_wdata act=%0h exp=0", mem_wdata); end
        checks++; if (mem_wstrb !== 4'h0) begin failures++; $display("FAIL rst_mem_wstrb act=%0h exp=0", mem_wstrb); end
        checks++; if (if_valid !== 1'b0 || dm_valid !== 1'b0) begin failures++; $display("FAIL rst_valids act=%0b%0b exp=00", if_valid, dm_valid); end
        checks++; if (dm_stall !== 1'b1 || if_stall !== 1'b0) begin failures++; $display("FAIL rst_stalls act=%0b%0b exp=01", if_stall, dm_stall); end
        dm_req = 1'b0; dm_we = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_if_only();
        int k_req, k_val;
        k_req = -1; k_val = -1;
        ack_lat = 2; rdata_ovr_en = 1'b1; rdata_ovr = 32'hDEADBEEF;
        if_addr = 32'h10; if_req = 1'b1;
        for (int k = 1; k <= 20 && k_val < 0; k++) begin
            @(negedge clk);
            if (mem_req && k_req < 0) begin
                k_req = k;
                checks++; if (mem_addr !== 32'h10 || mem_wstrb !== 4'h0 || mem_we !== 1'b0) begin
                    failures++; $display("FAIL ifonly_bus act=addr %0h strb %0h we %0b exp=addr 10 strb 0 we 0", mem_addr, mem_wstrb, mem_we); end
            end
            if (if_valid) begin
                k_val = k;
                checks++; if (if_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL ifonly_rdata act=%0h exp=deadbeef", if_rdata); end
            end
            checks++; if (if_stall !== (k < 3)) begin failures++; $display("FAIL ifonly_stall cyc=%0d act=%0b exp=%0b", k, if_stall, (k < 3)); end
        end
        checks++; if (k_req != 1 || k_val != 3) begin failures++; $display("FAIL ifonly_latency act=req@%0d valid@%0d exp=req@1 valid@3", k_req, k_val); end
        if_req = 1'b0; rdata_ovr_en = 1'b0; ack_lat = 0;
        @(negedge clk);
    endtask

    task automatic test_priority();
        int k_first, ka, k_second;
        bit got_if;
        k_first = -1; ka = -1; k_second = -1; got_if = 1'b0;
        if_addr = 32'h20; if_req = 1'b1;
        dm_addr = 32'h200; dm_we = 1'b0; dm_req = 1'b1;
        for (int k = 1; k <= 60 && !got_if; k++) begin
            @(negedge clk);
            if (mem_req && k_first < 0) begin
                k_first = k;
                checks++; if (mem_addr !== 32'h200) begin failures++; $display("FAIL prio_first_addr act=%0h exp=200", mem_addr); end
            end
            if (ka > 0 && k_second < 0 && k > ka && mem_req) begin
                k_second = k;
                checks++; if (mem_addr !== 32'h20) begin failures++; $display("FAIL prio_second_addr act=%0h exp=20", mem_addr); end
                checks++; if (k_second != ka + 2) begin failures++; $display("FAIL prio_bubble act=%0d exp=%0d", k_second, ka + 2); end
            end
            if (dm_valid) begin
                ka = k; dm_req = 1'b0;
                checks++; if (dm_rdata !== ref_read(32'h200)) begin failures++; $display("FAIL prio_dm_rdata act=%0h exp=%0h", dm_rdata, ref_read(32'h200)); end
            end
            if (if_valid) begin
                got_if = 1'b1; if_req = 1'b0;
                checks++; if (ka < 0 || if_rdata !== init_word(32'h20)) begin
                    failures++; $display("FAIL prio_if act=%0h dm_done=%0b exp=%0h dm_done=1", if_rdata, ka > 0, init_word(32'h20)); end
            end
        end
        checks++; if (!got_if) begin failures++; $display("FAIL prio_timeout act=no if_valid exp=if_valid"); end
        if_req = 1'b0; dm_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_store();
        bit seen, done;
        seen = 1'b0; done = 1'b0;
        dm_we = 1'b1; dm_addr = 32'h104; dm_wdata = 32'h12345678; dm_wstrb = 4'b0011; dm_req = 1'b1;
        for (int k = 1; k <= 40 && !done; k++) begin
            @(negedge clk);
            if (mem_req && !seen) begin
                seen = 1'b1;
                checks++; if (mem_we !== 1'b1 || mem_wstrb !== 4'b0011 || mem_wdata !== 32'h12345678 || mem_addr !== 32'h104) begin
                    failures++; $display("FAIL store_bus act=we %0b strb %0h wdata %0h addr %0h exp=we 1 strb 3 wdata 12345678 addr 104",
                                         mem_we, mem_wstrb, mem_wdata, mem_addr); end
            end
            if (dm_valid) begin
                done = 1'b1; dm_req = 1'b0;
                ref_mem[32'h104] = merge_word(ref_read(32'h104), 32'h12345678, 4'b0011);
            end
        end
        checks++; if (!done) begin failures++; $display("FAIL store_timeout act=no dm_valid exp=dm_valid"); end
        @(negedge clk);
        seen = 1'b0; done = 1'b0;
        dm_we = 1'b0; dm_req = 1'b1;
        for (int k = 1; k <= 40 && !done; k++) begin
            @(negedge clk);
            if (mem_req && !seen) begin
                seen = 1'b1;
                checks++; if (mem_wstrb !== 4'h0 || mem_we !== 1'b0) begin failures++; $display("FAIL load_strb act=%0h we %0b exp=0 we 0", mem_wstrb, mem_we); end
            end
            if (dm_valid) begin
                done = 1'b1; dm_req = 1'b0;
                checks++; if (dm_rdata !== ref_read(32'h104)) begin failures++; $display("FAIL store_readback act=%0h exp=%0h", dm_rdata, ref_read(32'h104)); end
            end
        end
        checks++; if (!done) begin failures++; $display("FAIL load_timeout act=no dm_valid exp=dm_valid"); end
        @(negedge clk);
    endtask

    task automatic test_starvation();
        byte seq[$];
        string exp_s;
        int n_dm, n_if;
        exp_s = "DDDDIDDDDI";
        n_dm = 0; n_if = 0;
        if_addr = 32'h40; if_req = 1'b1;
        dm_addr = 32'h300; dm_we = 1'b0; dm_req = 1'b1;
        for (int k = 1; k <= 400 && seq.size() < 10; k++) begin
            @(negedge clk);
            if (dm_valid) begin
                seq.push_back(8'h44); n_dm++;
                if (n_dm < 8) dm_addr = dm_addr + 32'h4; else dm_req = 1'b0;
            end
            if (if_valid) begin
                seq.push_back(8'h49); n_if++;
                if (n_if < 2) if_addr = if_addr + 32'h4; else if_req = 1'b0;
            end
        end
        checks++; if (seq.size() != 10) begin failures++; $display("FAIL starve_count act=%0d exp=10", seq.size()); end
        for (int i = 0; i < seq.size() && i < 10; i++) begin
            checks++; if (seq[i] !== exp_s[i]) begin failures++; $display("FAIL starve_order idx=%0d act=%c exp=%c", i, seq[i], exp_s[i]); end
        end
        if_req = 1'b0; dm_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_flush();
        int ka, kd;
        bit got_if;
        ka = -1; kd = -1; got_if = 1'b0;
        ack_lat = 3;
        dm_we = 1'b0; dm_addr = 32'h208; if_addr = 32'h30; if_req = 1'b1;
        @(negedge clk);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h30) begin failures++; $display("FAIL flush_grant act=req %0b addr %0h exp=req 1 addr 30", mem_req, mem_addr); end
        if_req = 1'b0;
        @(negedge clk);
        if_addr = 32'h34; if_req = 1'b1; dm_req = 1'b1;
        for (int k = 3; k <= 80 && !got_if; k++) begin
            @(negedge clk);
            if (mem_ack && ka < 0) begin
                ka = k;
                checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL flush_suppress act=%0b exp=0", if_valid); end
            end else if (ka > 0 && k == ka + 1) begin
                checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL flush_bubble act=%0b exp=0", mem_req); end
            end
            if (ka > 0 && kd < 0 && k > ka && mem_req) begin
                kd = k;
                checks++; if (kd != ka + 2 || mem_addr !== 32'h208) begin failures++; $display("FAIL flush_dm_grant act=cyc %0d addr %0h exp=cyc %0d addr 208", kd, mem_addr, ka + 2); end
            end
            if (dm_valid) begin
                dm_req = 1'b0;
                checks++; if (dm_rdata !== ref_read(32'h208)) begin failures++; $display("FAIL flush_dm_rdata act=%0h exp=%0h", dm_rdata, ref_read(32'h208)); end
            end
            if (if_valid) begin
                got_if = 1'b1; if_req = 1'b0;
                checks++; if (if_rdata !== init_word(32'h34) || kd < 0) begin failures++; $display("FAIL flush_if_rdata act=%0h exp=%0h", if_rdata, init_word(32'h34)); end
            end
        end
        checks++; if (!got_if) begin failures++; $display("FAIL flush_timeout act=no if_valid exp=if_valid"); end
        ack_lat = 0; if_req = 1'b0; dm_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_stray_ack();
        bit done;
        done = 1'b0;
        stray_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (if_valid !== 1'b0 || dm_valid !== 1'b0 || mem_req !== 1'b0) begin
                failures++; $display("FAIL stray_ack act=iv %0b dv %0b req %0b exp=0 0 0", if_valid, dm_valid, mem_req); end
        end
        stray_ack = 1'b0;
        @(negedge clk);
        dm_we = 1'b0; dm_addr = 32'h210; dm_req = 1'b1;
        for (int k = 1; k <= 40 && !done; k++) begin
            @(negedge clk);
            if (dm_valid) begin
                done = 1'b1; dm_req = 1'b0;
                checks++; if (dm_rdata !== ref_read(32'h210)) begin failures++; $display("FAIL stray_after_rdata act=%0h exp=%0h", dm_rdata, ref_read(32'h210)); end
            end
        end
        checks++; if (!done) begin failures++; $display("FAIL stray_after_timeout act=no dm_valid exp=dm_valid"); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int k_req;
        bit done;
        k_req = -1; done = 1'b0;
        ack_lat = 4;
        dm_we = 1'b0; dm_addr = 32'h20C; dm_req = 1'b1;
        @(negedge clk);
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rstmid_grant act=%0b exp=1", mem_req); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0 || dm_valid !== 1'b0) begin failures++; $display("FAIL rstmid_async act=req %0b dv %0b exp=0 0", mem_req, dm_valid); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (mem_req !== 1'b0 || dm_valid !== 1'b0) begin failures++; $display("FAIL rstmid_hold act=req %0b dv %0b exp=0 0", mem_req, dm_valid); end
        end
        rst = 1'b0;
        for (int k = 1; k <= 40 && !done; k++) begin
            @(negedge clk);
            if (mem_req && k_req < 0) begin
                k_req = k;
                checks++; if (k_req != 1 || mem_addr !== 32'h20C) begin failures++; $display("FAIL rstmid_regrant act=cyc %0d addr %0h exp=cyc 1 addr 20c", k_req, mem_addr); end
            end
            if (dm_valid) begin
                done = 1'b1; dm_req = 1'b0;
                checks++; if (dm_rdata !== ref_read(32'h20C)) begin failures++; $display("FAIL rstmid_rdata act=%0h exp=%0h", dm_rdata, ref_read(32'h20C)); end
            end
        end
        checks++; if (!done) begin failures++; $display("FAIL rstmid_timeout act=no dm_valid exp=dm_valid"); end
        ack_lat = 0;
        @(negedge clk);
    endtask

    task automatic test_random();
        int if_done, dm_done, if_gap, dm_gap, if_wait, dm_wait, dm_since_if;
        bit stuck;
        if_done = 0; dm_done = 0; if_gap = 0; dm_gap = 0; if_wait = 0; dm_wait = 0;
        dm_since_if = 0; stuck = 1'b0;
        if_req = 1'b0; dm_req = 1'b0; ack_lat = 0;
        for (int cyc = 0; cyc < 8000 && !stuck && (if_done < 60 || dm_done < 80); cyc++) begin
            @(negedge clk);
            checks++; if (if_stall !== (if_req & ~if_valid) || dm_stall !== (dm_req & ~dm_valid)) begin
                failures++; $display("FAIL rand_stall cyc=%0d act=%0b%0b exp=%0b%0b", cyc, if_stall, dm_stall, if_req & ~if_valid, dm_req & ~dm_valid); end
            if (if_valid) begin
                checks++; if (if_req !== 1'b1 || if_rdata !== init_word(if_addr)) begin
                    failures++; $display("FAIL rand_if cyc=%0d act=%0h req %0b exp=%0h req 1", cyc, if_rdata, if_req, init_word(if_addr)); end
                if_done++; if_req = 1'b0; if_gap = $urandom_range(0, 3); dm_since_if = 0;
            end
            if (dm_valid) begin
                checks++; if (dm_req !== 1'b1) begin failures++; $display("FAIL rand_dm_req cyc=%0d act=%0b exp=1", cyc, dm_req); end
                if (dm_we) begin
                    ref_mem[dm_addr] = merge_word(ref_read(dm_addr), dm_wdata, dm_wstrb);
                end else begin
                    checks++; if (dm_rdata !== ref_read(dm_addr)) begin
                        failures++; $display("FAIL rand_dm_rdata cyc=%0d addr=%0h act=%0h exp=%0h", cyc, dm_addr, dm_rdata, ref_read(dm_addr)); end
                end
                if (if_req) begin
                    dm_since_if++;
                    checks++; if (dm_since_if > STARVE_MAX + 1) begin failures++; $display("FAIL rand_starve act=%0d exp<=%0d", dm_since_if, STARVE_MAX + 1); end
                end
                dm_done++; dm_req = 1'b0; dm_gap = $urandom_range(0, 2);
            end
            if (if_req) if_wait++;
            if (dm_req) dm_wait++;
            if (if_wait > 150 || dm_wait > 150) begin
                stuck = 1'b1; failures++;
                $display("FAIL rand_timeout act=if_wait %0d dm_wait %0d exp<=150", if_wait, dm_wait);
            end
            if (!if_req && if_done < 60) begin
                if (if_gap == 0) begin
                    if_addr = 32'h1000 + 32'($urandom_range(0, 63)) * 32'h4;
                    if_req = 1'b1; if_wait = 0; dm_since_if = 0;
                end else begin
                    if_gap--;
                end
            end
            if (!dm_req && dm_done < 80) begin
                if (dm_gap == 0) begin
                    dm_addr  = 32'h2000 + 32'($urandom_range(0, 7)) * 32'h4;
                    dm_we    = 1'($urandom_range(0, 1));
                    dm_wdata = $urandom();
                    dm_wstrb = 4'($urandom_range(0, 15));
                    dm_req   = 1'b1; dm_wait = 0;
                end else begin
                    dm_gap--;
                end
            end
        end
        checks++; if (if_done < 60 || dm_done < 80) begin failures++; $display("FAIL rand_progress act=if %0d dm %0d exp=if 60 dm 80", if_done, dm_done); end
        if_req = 1'b0; dm_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_if_only();
        test_priority();
        test_store();
        test_starvation();
        test_flush();
        test_stray_ack();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
